// File: rtl/panel_seq_pkg.sv
// panel_seq_pkg -- shared definitions for the front-panel sequencer.
//   action_e   : step-table action codes
//   state_e    : sequencer FSM state encoding
//   STB_*      : bit positions inside the registered strobe vector
//   strobe_mask: maps a strobe action onto its one-hot strobe bit
package panel_seq_pkg;

  typedef enum logic [2:0] {
    ACT_NOP       = 3'd0,
    ACT_ADDR_LOAD = 3'd1,
    ACT_DEP       = 3'd2,
    ACT_EXAM      = 3'd3,
    ACT_CONT      = 3'd4,
    ACT_CLEAR     = 3'd5,
    ACT_EXTD_ADDR = 3'd6,
    ACT_WAIT_HALT = 3'd7
  } action_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_WAITH = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int STB_ADDR_LOAD = 0;
  localparam int STB_DEP       = 1;
  localparam int STB_EXAM      = 2;
  localparam int STB_CONT      = 3;
  localparam int STB_CLEAR     = 4;
  localparam int STB_EXTD_ADDR = 5;
  localparam int STB_W         = 6;

  // Active-high one-hot select; NOP and WAIT_HALT select nothing.
  function automatic logic [STB_W-1:0] strobe_mask(input action_e act);
    strobe_mask = '0;
    case (act)
      ACT_ADDR_LOAD: strobe_mask[STB_ADDR_LOAD] = 1'b1;
      ACT_DEP:       strobe_mask[STB_DEP]       = 1'b1;
      ACT_EXAM:      strobe_mask[STB_EXAM]      = 1'b1;
      ACT_CONT:      strobe_mask[STB_CONT]      = 1'b1;
      ACT_CLEAR:     strobe_mask[STB_CLEAR]     = 1'b1;
      ACT_EXTD_ADDR: strobe_mask[STB_EXTD_ADDR] = 1'b1;
      default:       strobe_mask = '0;
    endcase
  endfunction

endpackage

// File: rtl/panel_seq_watch.sv
// panel_seq_watch -- one address watch channel: a loadable compare address
// with enable, and a sticky hit flag.
//   clk, resetn          : clock, async active-low reset (clears all registers)
//   load, load_addr/on   : load the compare address and enable
//   address              : live CPU memory address
//   clear                : clear the sticky hit (accepted run start)
//   hit                  : sticky match flag
module panel_seq_watch (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [0:14] load_addr,
  input  logic        load_on,
  input  logic [0:14] address,
  input  logic        clear,
  output logic        hit
);

  logic [0:14] addr_q;
  logic        on_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
      on_q   <= 1'b0;
      hit    <= 1'b0;
    end else begin
      if (load) begin
        addr_q <= load_addr;
        on_q   <= load_on;
      end
      if (clear) begin
        hit <= 1'b0;
      end else if (on_q && (address == addr_q)) begin
        hit <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/panel_sequencer.sv
// panel_sequencer -- plays a small step table onto the front-panel switch
// register and active-low key strobes, with optional address watch channels.
//   clk, resetn                  : clock, async active-low reset
//   wr_*                         : step-table write port (ignored while busy)
//   n_steps, start, abort        : run control (n_steps clamped to STEPS)
//   cpu_halted, address          : CPU status inputs
//   watch_*                      : watch-channel load port
//   sr_out, *n strobes           : panel drives, strobes registered active-low
//   busy, done, halt_seen,
//   watch_hit                    : status
// Build option: define PANEL_SEQ_WATCH_EN to build the WATCH channels;
// otherwise watch_hit is tied low and the watch inputs are ignored.
//
// state | meaning
// IDLE  | waiting for start
// SETUP | one cycle, sr_out takes the step's switch value
// PULSE | selected strobe low for PULSE_CYCLES
// GAP   | post-step delay countdown
// WAITH | waiting for cpu_halted
// DONE  | one-cycle completion flag
module panel_sequencer
  import panel_seq_pkg::*;
#(
  parameter int STEPS        = 8,
  parameter int PULSE_CYCLES = 2,
  parameter int DELAY_W      = 16,
  parameter int WATCH        = 4,
  localparam int IDX_W       = $clog2(STEPS),
  localparam int N_W         = IDX_W + 1,
  localparam int WSEL_W      = (WATCH > 1) ? $clog2(WATCH) : 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [2:0]         wr_action,
  input  logic [0:11]        wr_sr,
  input  logic [DELAY_W-1:0] wr_delay,
  input  logic [N_W-1:0]     n_steps,
  input  logic               start,
  input  logic               abort,
  input  logic               cpu_halted,
  input  logic [0:14]        address,
  input  logic               watch_wr,
  input  logic [WSEL_W-1:0]  watch_sel,
  input  logic [0:14]        watch_addr,
  input  logic               watch_on,
  output logic [0:11]        sr_out,
  output logic               addr_loadn,
  output logic               depn,
  output logic               examn,
  output logic               contn,
  output logic               clearn,
  output logic               extd_addrn,
  output logic               busy,
  output logic               done,
  output logic               halt_seen,
  output logic [WATCH-1:0]   watch_hit
);

  localparam int PC_W  = $clog2(PULSE_CYCLES + 1);
  localparam int CNT_W = (DELAY_W > PC_W) ? DELAY_W : PC_W;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [STB_W-1:0]   strobe_q;
  logic [0:11]        sr_q;
  logic               halt_q;
  logic               halted_q;

  logic [2:0]         tbl_act [STEPS];
  logic [0:11]        tbl_sr  [STEPS];
  logic [DELAY_W-1:0] tbl_dly [STEPS];

  logic [2:0]         cur_act;
  logic [0:11]        cur_sr;
  logic [DELAY_W-1:0] cur_dly;
  logic [N_W-1:0]     n_clamp;
  logic               start_accept;
  logic               last_step;
  logic               post_action;
  logic               step_end;

  assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done = (state_q == ST_DONE);

  // Table has no reset so a loaded program survives a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en && !busy && ({1'b0, wr_idx} < N_W'(STEPS))) begin
      tbl_act[wr_idx] <= wr_action;
      tbl_sr[wr_idx]  <= wr_sr;
      tbl_dly[wr_idx] <= wr_delay;
    end
  end

  assign cur_act = tbl_act[step_q];
  assign cur_sr  = tbl_sr[step_q];
  assign cur_dly = tbl_dly[step_q];

  assign n_clamp      = (n_steps > N_W'(STEPS)) ? N_W'(STEPS) : n_steps;
  assign start_accept = start && !abort && !busy;
  assign last_step    = ({1'b0, step_q} == (n_q - N_W'(1)));

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    post_action = 1'b0;
    step_end    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start_accept) begin
          n_d     = n_clamp;
          step_d  = '0;
          state_d = (n_clamp == '0) ? ST_DONE : ST_SETUP;
        end
      end
      ST_SETUP: begin
        case (action_e'(cur_act))
          ACT_NOP:       post_action = 1'b1;
          ACT_WAIT_HALT: state_d = ST_WAITH;
          default: begin
            state_d = ST_PULSE;
            cnt_d   = CNT_W'(PULSE_CYCLES - 1);
          end
        endcase
      end
      ST_PULSE: begin
        if (cnt_q == '0) post_action = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      ST_GAP: begin
        if (cnt_q == '0) step_end = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      ST_WAITH: begin
        if (cpu_halted) post_action = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Zero delay skips GAP entirely so a step costs no idle cycle.
    if (post_action) begin
      if (cur_dly == '0) begin
        step_end = 1'b1;
      end else begin
        state_d = ST_GAP;
        cnt_d   = CNT_W'(cur_dly - DELAY_W'(1));
      end
    end

    if (step_end) begin
      if (last_step) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_SETUP;
        step_d  = step_q + IDX_W'(1);
      end
    end

    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      cnt_q    <= '0;
      n_q      <= '0;
      strobe_q <= '1;
      sr_q     <= '0;
      halt_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      halted_q <= cpu_halted;
      // Strobes come straight from a flop keyed on the next state, so they
      // are low exactly while the FSM sits in PULSE and never glitch.
      strobe_q <= (state_d == ST_PULSE) ? ~strobe_mask(action_e'(cur_act)) : '1;
      if (state_q == ST_SETUP) sr_q <= cur_sr;
      if (start_accept) begin
        halt_q <= 1'b0;
      end else if (((state_q == ST_WAITH) && cpu_halted) ||
                   (busy && cpu_halted && !halted_q)) begin
        halt_q <= 1'b1;
      end
    end
  end

  assign sr_out     = sr_q;
  assign halt_seen  = halt_q;
  assign addr_loadn = strobe_q[STB_ADDR_LOAD];
  assign depn       = strobe_q[STB_DEP];
  assign examn      = strobe_q[STB_EXAM];
  assign contn      = strobe_q[STB_CONT];
  assign clearn     = strobe_q[STB_CLEAR];
  assign extd_addrn = strobe_q[STB_EXTD_ADDR];

`ifdef PANEL_SEQ_WATCH_EN
  for (genvar k = 0; k < WATCH; k++) begin : g_watch
    panel_seq_watch u_watch (
      .clk       (clk),
      .resetn    (resetn),
      .load      (watch_wr && (watch_sel == WSEL_W'(k))),
      .load_addr (watch_addr),
      .load_on   (watch_on),
      .address   (address),
      .clear     (start_accept),
      .hit       (watch_hit[k])
    );
  end
`else
  logic unused_watch;
  assign unused_watch = ^{watch_wr, watch_sel, watch_addr, watch_on, address};
  assign watch_hit    = '0;
`endif

endmodule

// File: tb/tb_panel_sequencer.sv
// tb_panel_sequencer -- self-checking bench for panel_sequencer.
// Expected per-cycle strobes, sr_out, busy and done come from a timeline
// model built from the step rules (setup 1, pulse, halt wait, delay).
module tb_panel_sequencer;

  localparam int STEPS = 8;
  localparam int PC    = 2;
  localparam int DW    = 16;
  localparam int WATCH = 4;
`ifdef PANEL_SEQ_WATCH_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic          clk;
  logic          resetn;
  logic          wr_en;
  logic [2:0]    wr_idx;
  logic [2:0]    wr_action;
  logic [0:11]   wr_sr;
  logic [DW-1:0] wr_delay;
  logic [3:0]    n_steps;
  logic          start;
  logic          abort;
  logic          cpu_halted;
  logic [0:14]   address;
  logic          watch_wr;
  logic [1:0]    watch_sel;
  logic [0:14]   watch_addr;
  logic          watch_on;
  logic [0:11]   sr_out;
  logic          addr_loadn, depn, examn, contn, clearn, extd_addrn;
  logic          busy, done, halt_seen;
  logic [WATCH-1:0] watch_hit;

  panel_sequencer #(
    .STEPS(STEPS), .PULSE_CYCLES(PC), .DELAY_W(DW), .WATCH(WATCH)
  ) dut (
    .clk(clk), .resetn(resetn),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_action(wr_action), .wr_sr(wr_sr),
    .wr_delay(wr_delay), .n_steps(n_steps), .start(start), .abort(abort),
    .cpu_halted(cpu_halted), .address(address),
    .watch_wr(watch_wr), .watch_sel(watch_sel), .watch_addr(watch_addr),
    .watch_on(watch_on),
    .sr_out(sr_out), .addr_loadn(addr_loadn), .depn(depn), .examn(examn),
    .contn(contn), .clearn(clearn), .extd_addrn(extd_addrn),
    .busy(busy), .done(done), .halt_seen(halt_seen), .watch_hit(watch_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          m_act [STEPS];
  logic [0:11] m_sr  [STEPS];
  int          m_dly [STEPS];
  logic [0:11] prev_sr;
  logic [5:0]  exp_stb [0:1023];
  logic [0:11] exp_sr  [0:1023];

  function automatic logic [5:0] stb_now();
    return {extd_addrn, clearn, contn, examn, depn, addr_loadn};
  endfunction

  task automatic write_step(input int idx, input int act, input logic [0:11] sr, input int dly);
    wr_en = 1'b1; wr_idx = 3'(idx); wr_action = 3'(act); wr_sr = sr; wr_delay = DW'(dly);
    @(posedge clk); #1;
    wr_en = 1'b0;
    m_act[idx] = act; m_sr[idx] = sr; m_dly[idx] = dly;
  endtask

  // Run n steps from step 0; halt_at = cycle on which cpu_halted rises (-1 none);
  // poke = cycle on which a start and a table write are thrown at the busy DUT.
  task automatic run_seq(input int n, input int halt_at, input int poke);
    int nn, t, w_end, tend;
    logic [0:11] cur;
    logic [5:0] one;
    nn = (n > STEPS) ? STEPS : n;
    t = 0; cur = prev_sr;
    for (int i = 0; i < nn; i++) begin
      exp_stb[t] = 6'h3f; exp_sr[t] = cur; t++;
      cur = m_sr[i];
      if (m_act[i] >= 1 && m_act[i] <= 6) begin
        one = 6'b000001 << (m_act[i] - 1);
        for (int k = 0; k < PC; k++) begin exp_stb[t] = ~one; exp_sr[t] = cur; t++; end
      end else if (m_act[i] == 7) begin
        w_end = (halt_at > t) ? halt_at : t;
        while (t <= w_end) begin exp_stb[t] = 6'h3f; exp_sr[t] = cur; t++; end
      end
      for (int k = 0; k < m_dly[i]; k++) begin exp_stb[t] = 6'h3f; exp_sr[t] = cur; t++; end
    end
    tend = t;
    for (int k = 0; k < 3; k++) begin exp_stb[tend+k] = 6'h3f; exp_sr[tend+k] = cur; end

    n_steps = 4'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c <= tend + 2; c++) begin
      @(negedge clk);
      checks++;
      if (stb_now() !== exp_stb[c]) begin
        errors++; $display("FAIL strobes cycle %0d: got %b want %b", c, stb_now(), exp_stb[c]);
      end
      checks++;
      if (sr_out !== exp_sr[c]) begin
        errors++; $display("FAIL sr_out cycle %0d: got %o want %o", c, sr_out, exp_sr[c]);
      end
      checks++;
      if (done !== (c == tend)) begin
        errors++; $display("FAIL done cycle %0d: got %b want %b", c, done, (c == tend));
      end
      checks++;
      if (busy !== (c < tend)) begin
        errors++; $display("FAIL busy cycle %0d: got %b want %b", c, busy, (c < tend));
      end
      if (c == tend) begin
        checks++;
        if (halt_seen !== (halt_at >= 0 && halt_at < tend)) begin
          errors++; $display("FAIL halt_seen at done: got %b want %b", halt_seen, (halt_at >= 0 && halt_at < tend));
        end
      end
      if (c == halt_at) cpu_halted = 1'b1;
      if (c == poke && poke < tend) begin
        start = 1'b1; wr_en = 1'b1; wr_idx = 3'd0; wr_action = 3'd5;
        wr_sr = 12'o7070; wr_delay = DW'(3);
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
    end
    prev_sr = cur;
  endtask

  task automatic test_reset();
    resetn = 1'b0; wr_en = 0; wr_idx = 0; wr_action = 0; wr_sr = 0; wr_delay = 0;
    n_steps = 0; start = 0; abort = 0; cpu_halted = 0; address = 0;
    watch_wr = 0; watch_sel = 0; watch_addr = 0; watch_on = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (stb_now() !== 6'h3f || sr_out !== 12'o0000) begin
      errors++; $display("FAIL reset_drives: strobes %b sr %o want 111111 0000", stb_now(), sr_out);
    end
    checks++;
    if ({busy, done, halt_seen} !== 3'b000 || watch_hit !== '0) begin
      errors++; $display("FAIL reset_status: bdh %b hit %b want 000 0", {busy, done, halt_seen}, watch_hit);
    end
    resetn = 1'b1;
    prev_sr = 12'o0000;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || stb_now() !== 6'h3f) begin
      errors++; $display("FAIL post_reset_idle: busy %b strobes %b", busy, stb_now());
    end
  endtask

  task automatic test_single_load();
    write_step(0, 1, 12'o0200, 10);
    run_seq(1, -1, -1);
  endtask

  task automatic test_sequence();
    write_step(0, 1, 12'o0020, $urandom_range(0, 4));
    write_step(1, 2, 12'o0002, $urandom_range(0, 4));
    write_step(2, 2, 12'o0304, $urandom_range(0, 4));
    write_step(3, 4, 12'o0000, $urandom_range(0, 4));
    run_seq(4, -1, -1);
  endtask

  task automatic test_wait_halt();
    write_step(0, 7, 12'o0001, $urandom_range(0, 4));
    write_step(1, 4, 12'o0000, $urandom_range(0, 4));
    run_seq(2, 500, -1);
    cpu_halted = 1'b0;
    write_step(0, 1, 12'o1234, 8);
    run_seq(1, 3, -1);
    cpu_halted = 1'b0;
    write_step(0, 3, 12'o4321, 2);
    run_seq(1, -1, -1);
  endtask

  task automatic test_abort();
    bit found;
    write_step(0, 1, 12'o0001, 0);
    write_step(1, 2, 12'o0055, 3);
    write_step(2, 4, 12'o0000, 1);
    n_steps = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (depn === 1'b0) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL abort_reach_dep: got no depn pulse want one within 40 cycles");
      repeat (40) @(negedge clk);
    end else begin
      abort = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
      checks++;
      if (stb_now() !== 6'h3f || busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL abort_response: strobes %b busy %b done %b want 111111 0 0", stb_now(), busy, done);
      end
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          errors++; $display("FAIL abort_quiet cycle %0d: done %b busy %b want 0 0", c, done, busy);
        end
      end
    end
    prev_sr = 12'o0055;
    run_seq(3, -1, -1);
  endtask

  task automatic test_watch();
    logic [WATCH-1:0] exp_hit;
    exp_hit = WEN ? 4'b0001 : 4'b0000;
    address = 15'o00000;
    @(negedge clk);
    checks++;
    if (watch_hit !== 4'b0000) begin
      errors++; $display("FAIL watch_initial: got %b want 0000", watch_hit);
    end
    watch_wr = 1'b1; watch_sel = 2'd0; watch_addr = 15'o05276; watch_on = 1'b1;
    @(posedge clk); #1;
    watch_sel = 2'd1; watch_on = 1'b0;
    @(posedge clk); #1;
    watch_sel = 2'd2; watch_addr = 15'o01234; watch_on = 1'b1;
    @(posedge clk); #1;
    watch_wr = 1'b0;
    @(negedge clk); address = 15'o05276;
    @(negedge clk); address = 15'o05275;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (watch_hit !== exp_hit) begin
        errors++; $display("FAIL watch_sticky cycle %0d: got %b want %b", c, watch_hit, exp_hit);
      end
    end
    run_seq(0, -1, -1);
    checks++;
    if (watch_hit !== 4'b0000) begin
      errors++; $display("FAIL watch_clear_on_start: got %b want 0000", watch_hit);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < STEPS; i++)
      write_step(i, $urandom_range(0, 6), 12'($urandom), $urandom_range(0, 3));
    run_seq(12, -1, $urandom_range(0, 15));
    run_seq(STEPS, -1, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < STEPS; i++)
        write_step(i, $urandom_range(0, 6), 12'($urandom), $urandom_range(0, 5));
      run_seq($urandom_range(0, 10), -1, $urandom_range(0, 30));
    end
  endtask

  task automatic test_async_reset();
    bit found;
    write_step(0, 1, 12'o7777, 20);
    n_steps = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (addr_loadn === 1'b0) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL async_reach_pulse: got no addr_loadn pulse want one within 10 cycles");
    end
    #3 resetn = 1'b0;
    #1;
    checks++;
    if (stb_now() !== 6'h3f || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset_now: strobes %b busy %b want 111111 0", stb_now(), busy);
    end
    checks++;
    if (sr_out !== 12'o0000 || done !== 1'b0 || halt_seen !== 1'b0) begin
      errors++; $display("FAIL async_reset_regs: sr %o done %b halt %b want 0000 0 0", sr_out, done, halt_seen);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    prev_sr = 12'o0000;
    address = 15'o05276;
    repeat (2) @(negedge clk);
    checks++;
    if (watch_hit !== 4'b0000) begin
      errors++; $display("FAIL watch_regs_reset: got %b want 0000", watch_hit);
    end
    address = 15'o00000;
    run_seq(1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_sequence();
    test_wait_halt();
    test_abort();
    test_watch();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/panel_sequencer.md
PANEL_SEQUENCER -- requirements
Module: panel_sequencer

Interface
REQ-001 Parameter STEPS, default 8: depth of the step table (2..64).
REQ-002 Parameter PULSE_CYCLES, default 2: clk cycles each switch strobe is held active.
REQ-003 Parameter DELAY_W, default 16: width of the per-step post-strobe delay field.
REQ-004 Parameter WATCH, default 4: number of address watch channels (1..8).
REQ-005 clk  in  1  system clock; the single clock for all state.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 wr_en, wr_idx[$clog2(STEPS)-1:0], wr_action[2:0], wr_sr[0:11], wr_delay[DELAY_W-1:0]  in  step-table write port.
REQ-008 n_steps[$clog2(STEPS):0], start, abort  in  run control.
REQ-009 cpu_halted  in  1  CPU is in H0 on a HLT instruction.
REQ-010 address[0:14]  in  current CPU memory address.
REQ-011 watch_wr, watch_sel, watch_addr[0:14], watch_on  in  watch-channel load port.
REQ-012 sr_out[0:11], addr_loadn, depn, examn, contn, clearn, extd_addrn  out  panel drives; all strobes active-low.
REQ-013 busy, done, halt_seen, watch_hit[WATCH-1:0]  out  status.

Function
REQ-014 Actions: 0 NOP, 1 ADDR_LOAD, 2 DEP, 3 EXAM, 4 CONT, 5 CLEAR, 6 EXTD_ADDR, 7 WAIT_HALT.
REQ-015 States: IDLE, SETUP, PULSE, GAP, WAITH, DONE.
REQ-016 IDLE: start with n_steps>0 -> SETUP at step 0, busy=1; start with n_steps=0 -> DONE.
REQ-017 SETUP (1 cycle): sr_out loaded from the step's sr field; next PULSE for strobe actions, GAP for NOP, WAITH for WAIT_HALT.
REQ-018 PULSE: exactly one strobe, selected by action, low for exactly PULSE_CYCLES cycles; then GAP.
REQ-019 GAP: wait delay cycles (0 = no wait), then advance; after step n_steps-1 -> DONE.
REQ-020 WAITH: remain until cpu_halted=1, set halt_seen, then GAP using the step's delay.
REQ-021 DONE: done=1, busy=0 for one cycle, then IDLE; sr_out holds its last value.
REQ-022 At most one strobe is active in any cycle; strobes are registered and glitch-free.
REQ-023 abort in any non-IDLE state: all strobes high next cycle, -> IDLE, done not asserted; abort wins over a simultaneous start.
REQ-024 start while busy is ignored; wr_en while busy is ignored; n_steps>STEPS is clamped to STEPS.
REQ-025 cpu_halted rising outside WAITH while busy also sets halt_seen; halt_seen clears on accepted start.
REQ-026 Watch channel k hits when watch_on[k] and address==watch_addr[k]; watch_hit[k] is sticky until accepted start.

Reset
REQ-027 resetn low: state IDLE, all strobes 1, sr_out 0000, busy/done/halt_seen 0, watch_hit 0, watch registers cleared; takes effect asynchronously even mid-PULSE.
REQ-028 The step table is not cleared by reset.

Configuration
REQ-029 Macro PANEL_SEQ_WATCH_EN defined: WATCH channels built per REQ-026; undefined: no channel logic, watch_hit tied 0, watch_* inputs ignored.

Structure
REQ-030 Package panel_seq_pkg holds action codes, the state encoding, and the strobe-vector bit positions.
REQ-031 One sub-module, panel_seq_watch (single comparator plus sticky flag), instantiated WATCH times under PANEL_SEQ_WATCH_EN.

Verification
REQ-032 Load step 0 = ADDR_LOAD sr 0200 delay 10, n_steps=1, start -> sr_out=0200, addr_loadn low exactly 2 cycles, done 13 cycles after SETUP entry.
REQ-033 Steps ADDR_LOAD 0020, DEP 0002, DEP 0304, CONT 0000 -> strobes in order, never overlapping, sr_out matching each step.
REQ-034 Step WAIT_HALT then CONT; raise cpu_halted after 500 cycles -> halt_seen=1, contn pulses after the GAP, done follows.
REQ-035 Assert abort during PULSE of DEP -> depn high next cycle, IDLE, done never asserted; restart runs from step 0.
REQ-036 Watch 0 = 05276, watch_on; drive address 05276 once -> watch_hit[0]=1 until next start; without PANEL_SEQ_WATCH_EN -> stays 0.
REQ-037 Drop resetn mid-PULSE -> all strobes high and busy=0 immediately, without waiting for a clk edge.
